// File: rtl/label_pkg.sv
// Shared types and defaults for the multi-channel label filter.
package label_pkg;

    // Clear-sweep controller states.
    typedef enum logic {
        IDLE  = 1'b0,
        CLEAR = 1'b1
    } state_t;

    localparam int LABEL_W_DEF = 8;
    localparam int CNT_W_DEF   = 16;

    // Channel-select width; a single-channel build still gets a 1-bit select.
    function automatic int ch_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/label_table.sv
// One channel's label enable table: write port, single-address clear port
// and a registered read of the addressed enable bit.
module label_table
    import label_pkg::*;
#(
    parameter int LABEL_W = LABEL_W_DEF
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               wr_en,
    input  logic [LABEL_W-1:0] wr_adr,
    input  logic               wr_bit,
    input  logic               clr_en,
    input  logic [LABEL_W-1:0] clr_adr,
    input  logic [LABEL_W-1:0] rd_adr,
    output logic               rd_bit
);

    localparam int DEPTH = 1 << LABEL_W;

    logic [DEPTH-1:0] mem;

    // Enable bits; the sweep clear wins over a write, though the top never issues both.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mem <= '0;
        end else if (clr_en) begin
            mem[clr_adr] <= 1'b0;
        end else if (wr_en) begin
            mem[wr_adr] <= wr_bit;
        end
    end

    // Registered read returns the value held before any same-edge write.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_bit <= 1'b0;
        end else begin
            rd_bit <= mem[rd_adr];
        end
    end

endmodule

// File: rtl/label_filter_mc.sv
// Multi-channel receive label filter: per-channel enable tables, a
// clear-all sweep, one-cycle lookup with bypass, and saturating per-channel
// accepted-word counters.
module label_filter_mc
    import label_pkg::*;
#(
    parameter  int NUM_CH  = 2,
    parameter  int LABEL_W = LABEL_W_DEF,
    parameter  int CNT_W   = CNT_W_DEF,
    localparam int CH_W    = ch_w(NUM_CH)
) (
    input  logic               Clk,
    input  logic               Rst_n,
    input  logic               Wr,
    input  logic [CH_W-1:0]    Wr_ch,
    input  logic [LABEL_W-1:0] Label_adr,
    input  logic               Label_en,
    input  logic               Clr,
    output logic               Busy,
    output logic               Wr_err,
    input  logic               Chk_vld,
    input  logic [CH_W-1:0]    Chk_ch,
    input  logic [LABEL_W-1:0] Label_in,
    input  logic [NUM_CH-1:0]  Bypass,
    output logic               Match_vld,
    output logic [CH_W-1:0]    Match_ch,
    output logic               Label_out,
    input  logic [CH_W-1:0]    Cnt_sel,
    output logic [CNT_W-1:0]   Cnt_out
);

    // Saturating increment: holds at all-ones instead of wrapping.
    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (&v) ? v : v + CNT_W'(1);
    endfunction

    state_t               state;
    state_t               state_nxt;
    logic [LABEL_W-1:0]   swp_adr;
    logic                 busy;
    logic                 wr_ch_ok;
    logic                 chk_ch_ok;
    logic                 wr_ok;
    logic                 chk_ok;
    logic [NUM_CH-1:0]    rd_bits;
    logic                 vld_p1;
    logic [CH_W-1:0]      ch_p1;
    logic                 byp_p1;
    logic                 busy_p1;
    logic [CNT_W-1:0]     cnt [NUM_CH];

    assign wr_ch_ok  = 32'(Wr_ch)  < NUM_CH;
    assign chk_ch_ok = 32'(Chk_ch) < NUM_CH;
    assign wr_ok     = Wr & ~busy & wr_ch_ok;
    assign chk_ok    = Chk_vld & chk_ch_ok;
    assign Busy      = busy;

    // Sweep controller next state; Clr during a sweep keeps it in CLEAR.
    always_comb begin
        state_nxt = state;
        busy      = (state == CLEAR);
        case (state)
            IDLE:    if (Clr) state_nxt = CLEAR;
            CLEAR:   if (!Clr && (&swp_adr)) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Sweep controller state register.
    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Sweep address: restarts on Clr, advances while sweeping, wraps back to 0 at the end.
    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            swp_adr <= '0;
        end else if (Clr) begin
            swp_adr <= '0;
        end else if (busy) begin
            swp_adr <= swp_adr + LABEL_W'(1);
        end
    end

    // Rejected write flag: writes during a sweep or to a nonexistent channel.
    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            Wr_err <= 1'b0;
        end else begin
            Wr_err <= Wr & (busy | ~wr_ch_ok);
        end
    end

    for (genvar g = 0; g < NUM_CH; g++) begin : g_tbl
        label_table #(
            .LABEL_W (LABEL_W)
        ) u_tbl (
            .clk     (Clk),
            .rst_n   (Rst_n),
            .wr_en   (wr_ok && (Wr_ch == CH_W'(g))),
            .wr_adr  (Label_adr),
            .wr_bit  (Label_en),
            .clr_en  (busy),
            .clr_adr (swp_adr),
            .rd_adr  (Label_in),
            .rd_bit  (rd_bits[g])
        );
    end

    // Lookup stage p0 -> p1: carry channel, bypass and sweep status with the table read.
    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            vld_p1  <= 1'b0;
            ch_p1   <= '0;
            byp_p1  <= 1'b0;
            busy_p1 <= 1'b0;
        end else begin
            vld_p1 <= chk_ok;
            if (chk_ok) begin
                ch_p1   <= Chk_ch;
                byp_p1  <= Bypass[Chk_ch];
                busy_p1 <= busy;
            end
        end
    end

    assign Match_vld = vld_p1;
    assign Match_ch  = ch_p1;
    assign Label_out = vld_p1 & (byp_p1 | (~busy_p1 & rd_bits[ch_p1]));

    // Accepted-word counters, one per channel, bumped by each accepted result.
    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            for (int i = 0; i < NUM_CH; i++) cnt[i] <= '0;
        end else if (Match_vld && Label_out) begin
            cnt[ch_p1] <= sat_inc(cnt[ch_p1]);
        end
    end

    // Counter read mux; an out-of-range select reads zero.
    always_comb begin
        Cnt_out = '0;
        if (32'(Cnt_sel) < NUM_CH) Cnt_out = cnt[Cnt_sel];
    end

endmodule

// File: tb/tb_label_filter_mc.sv
// Self-checking bench for label_filter_mc: directed scenarios with literal
// expectations plus a randomized phase against a behavioural model.
module tb_label_filter_mc;

    localparam int NUM_CH  = 2;
    localparam int LABEL_W = 8;
    localparam int CNT_W   = 4;
    localparam int DEPTH   = 256;
    localparam int CNT_MAX = 15;

    logic         Clk = 1'b0;
    logic         Rst_n = 1'b0;
    logic         Wr = 1'b0;
    logic [0:0]   Wr_ch = '0;
    logic [7:0]   Label_adr = '0;
    logic         Label_en = 1'b0;
    logic         Clr = 1'b0;
    logic         Busy;
    logic         Wr_err;
    logic         Chk_vld = 1'b0;
    logic [0:0]   Chk_ch = '0;
    logic [7:0]   Label_in = '0;
    logic [1:0]   Bypass = '0;
    logic         Match_vld;
    logic [0:0]   Match_ch;
    logic         Label_out;
    logic [0:0]   Cnt_sel = '0;
    logic [3:0]   Cnt_out;

    always #5 Clk = ~Clk;

    label_filter_mc #(
        .NUM_CH  (NUM_CH),
        .LABEL_W (LABEL_W),
        .CNT_W   (CNT_W)
    ) dut (
        .Clk       (Clk),
        .Rst_n     (Rst_n),
        .Wr        (Wr),
        .Wr_ch     (Wr_ch),
        .Label_adr (Label_adr),
        .Label_en  (Label_en),
        .Clr       (Clr),
        .Busy      (Busy),
        .Wr_err    (Wr_err),
        .Chk_vld   (Chk_vld),
        .Chk_ch    (Chk_ch),
        .Label_in  (Label_in),
        .Bypass    (Bypass),
        .Match_vld (Match_vld),
        .Match_ch  (Match_ch),
        .Label_out (Label_out),
        .Cnt_sel   (Cnt_sel),
        .Cnt_out   (Cnt_out)
    );

    int n_chk  = 0;
    int n_fail = 0;

    task automatic check(input string name, input longint act, input longint exp);
        n_chk++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    bit m_tbl [NUM_CH][DEPTH];
    int m_cnt [NUM_CH];
    int m_left = 0;     // sweep cycles still to run
    int m_adr  = 0;     // next address the sweep clears
    bit e_vld = 0, e_out = 0, e_err = 0;
    int e_ch = 0;

    always @(posedge Clk) begin
        bit busy_now;
        if (!Rst_n) begin
            foreach (m_tbl[c, a]) m_tbl[c][a] = 1'b0;
            foreach (m_cnt[c]) m_cnt[c] = 0;
            m_left = 0; m_adr = 0;
            e_vld = 0; e_out = 0; e_err = 0; e_ch = 0;
        end else begin
            if (e_vld && e_out && m_cnt[e_ch] < CNT_MAX) m_cnt[e_ch]++;
            busy_now = (m_left > 0);
            e_vld = Chk_vld;
            if (Chk_vld) e_ch = int'(Chk_ch);
            e_out = Chk_vld && (Bypass[Chk_ch] || (!busy_now && m_tbl[Chk_ch][Label_in]));
            e_err = Wr && busy_now;
            if (Wr && !busy_now) m_tbl[Wr_ch][Label_adr] = Label_en;
            if (busy_now) for (int c = 0; c < NUM_CH; c++) m_tbl[c][m_adr] = 1'b0;
            if (Clr) begin
                m_left = DEPTH; m_adr = 0;
            end else if (busy_now) begin
                m_left--; m_adr = (m_adr + 1) % DEPTH;
            end
        end
        #1;
        check("busy", Busy, (m_left > 0));
        check("wr_err", Wr_err, e_err);
        check("match_vld", Match_vld, e_vld);
        check("label_out", Label_out, e_out);
        if (e_vld) check("match_ch", Match_ch, e_ch);
        check("cnt_out", Cnt_out, m_cnt[Cnt_sel]);
    end

    // ---------------- stimulus helpers (called at a falling edge) ----------------
    task automatic do_write(input int ch, input int adr, input bit en);
        Wr = 1'b1; Wr_ch = 1'(ch); Label_adr = 8'(adr); Label_en = en;
        @(negedge Clk);
        Wr = 1'b0;
    endtask

    task automatic do_lookup(input int ch, input int lab, input bit exp, input string name);
        Chk_vld = 1'b1; Chk_ch = 1'(ch); Label_in = 8'(lab);
        @(negedge Clk);
        Chk_vld = 1'b0;
        check({name, "_vld"}, Match_vld, 1);
        check({name, "_out"}, Label_out, exp);
    endtask

    int busy_cnt;
    int adrs [3] = '{0, 128, 255};

    initial begin
        // Reset and reset state
        Rst_n = 1'b0;
        repeat (3) @(negedge Clk);
        Rst_n = 1'b1;
        @(negedge Clk);
        check("rst_busy", Busy, 0);
        check("rst_vld", Match_vld, 0);
        check("rst_out", Label_out, 0);
        check("rst_err", Wr_err, 0);
        check("rst_cnt0", Cnt_out, 0);

        // Write then lookup on both channels
        do_write(0, 5, 1'b1);
        do_lookup(0, 5, 1'b1, "s1_ch0");
        do_lookup(1, 5, 1'b0, "s1_ch1");

        // Same-cycle write and lookup returns the old value
        Wr = 1'b1; Wr_ch = 1'b0; Label_adr = 8'd9; Label_en = 1'b1;
        Chk_vld = 1'b1; Chk_ch = 1'b0; Label_in = 8'd9;
        @(negedge Clk);
        Wr = 1'b0;
        check("s2_first_out", Label_out, 0);
        @(negedge Clk);
        Chk_vld = 1'b0;
        check("s2_repeat_out", Label_out, 1);

        // Populate, sweep, rejected write, bypass during sweep
        for (int c = 0; c < NUM_CH; c++)
            for (int k = 0; k < 3; k++) do_write(c, adrs[k], 1'b1);
        Bypass = 2'b10;
        Clr = 1'b1;
        @(negedge Clk);
        Clr = 1'b0;
        busy_cnt = 0;
        for (int i = 0; i < 400; i++) begin
            if (!Busy) break;
            busy_cnt++;
            if (busy_cnt == 50) begin
                Wr = 1'b1; Wr_ch = 1'b0; Label_adr = 8'd3; Label_en = 1'b1;
            end
            if (busy_cnt == 51) begin
                Wr = 1'b0;
                check("s3_wr_err", Wr_err, 1);
            end
            if (busy_cnt == 60) begin
                Chk_vld = 1'b1; Chk_ch = 1'b1; Label_in = 8'd0;
            end
            if (busy_cnt == 61) begin
                check("s4_sweep_ch1", Label_out, 1);
                Chk_ch = 1'b0; Label_in = 8'd128;
            end
            if (busy_cnt == 62) begin
                check("s4_sweep_ch0", Label_out, 0);
                Chk_vld = 1'b0;
            end
            @(negedge Clk);
        end
        check("s3_busy_cycles", busy_cnt, 256);
        do_lookup(1, 0, 1'b1, "s4_byp_ch1");
        do_lookup(0, 0, 1'b0, "s3_ch0_a0");
        do_lookup(0, 128, 1'b0, "s3_ch0_a128");
        do_lookup(0, 255, 1'b0, "s3_ch0_a255");
        do_lookup(0, 3, 1'b0, "s3_ch0_a3");
        Bypass = 2'b00;
        do_lookup(1, 0, 1'b0, "s3_ch1_a0");
        do_lookup(1, 128, 1'b0, "s3_ch1_a128");
        do_lookup(1, 255, 1'b0, "s3_ch1_a255");
        @(negedge Clk);
        Cnt_sel = 1'b0; #1;
        check("cnt_ch0_pre", Cnt_out, 2);
        Cnt_sel = 1'b1; #1;
        check("cnt_ch1_pre", Cnt_out, 2);
        @(negedge Clk);

        // Reset in the middle of a sweep
        do_write(0, 200, 1'b1);
        do_write(1, 150, 1'b1);
        Clr = 1'b1;
        @(negedge Clk);
        Clr = 1'b0;
        repeat (100) @(negedge Clk);
        check("s6_busy_before", Busy, 1);
        Rst_n = 1'b0;
        #1;
        check("s6_busy_async", Busy, 0);
        check("s6_cnt_async", Cnt_out, 0);
        @(negedge Clk);
        Rst_n = 1'b1;
        @(negedge Clk);
        check("s6_busy_after", Busy, 0);
        do_lookup(0, 200, 1'b0, "s6_ch0_a200");
        do_lookup(1, 150, 1'b0, "s6_ch1_a150");
        do_lookup(0, 5, 1'b0, "s6_ch0_a5");
        do_lookup(0, 9, 1'b0, "s6_ch0_a9");

        // Counter saturation with 20 accepted words on ch0
        Bypass = 2'b01;
        Chk_vld = 1'b1; Chk_ch = 1'b0;
        for (int i = 0; i < 20; i++) begin
            Label_in = 8'($urandom_range(0, 255));
            @(negedge Clk);
        end
        Chk_vld = 1'b0;
        repeat (2) @(negedge Clk);
        Cnt_sel = 1'b0; #1;
        check("s5_cnt_ch0_sat", Cnt_out, 15);
        Cnt_sel = 1'b1; #1;
        check("s5_cnt_ch1", Cnt_out, 0);
        @(negedge Clk);
        Bypass = 2'b00;

        // Randomized traffic
        for (int i = 0; i < 4000; i++) begin
            Rst_n     = ($urandom_range(0, 699) != 0);
            Wr        = ($urandom_range(0, 3) == 0);
            Wr_ch     = 1'($urandom_range(0, 1));
            Label_adr = ($urandom_range(0, 7) == 0) ? 8'($urandom_range(0, 255)) : 8'($urandom_range(0, 15));
            Label_en  = 1'($urandom_range(0, 1));
            Chk_vld   = 1'($urandom_range(0, 1));
            Chk_ch    = 1'($urandom_range(0, 1));
            Label_in  = ($urandom_range(0, 7) == 0) ? 8'($urandom_range(0, 255)) : 8'($urandom_range(0, 15));
            Clr       = ($urandom_range(0, 499) == 0);
            if ($urandom_range(0, 49) == 0) Bypass = 2'($urandom_range(0, 3));
            Cnt_sel   = 1'($urandom_range(0, 1));
            @(negedge Clk);
        end
        Rst_n = 1'b1; Wr = 1'b0; Chk_vld = 1'b0; Clr = 1'b0;
        repeat (3) @(negedge Clk);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not complete, got timeout, expected finish");
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/label_filter_mc.md
LABEL_FILTER_MC -- requirements
Module: label_filter_mc

Interface
REQ-001 The block SHALL have parameter NUM_CH, default 2: number of independent receive channels (1..8).
REQ-002 The block SHALL have parameter LABEL_W, default 8: label width; each channel table holds 2**LABEL_W enable bits.
REQ-003 The block SHALL have parameter CNT_W, default 16: width of the per-channel accepted-word counter.
REQ-004 Port Clk, input, 1: single clock; all logic is rising-edge.
REQ-005 Port Rst_n, input, 1: asynchronous active-low reset.
REQ-006 Port Wr, input, 1: table write strobe.
REQ-007 Port Wr_ch, input, clog2(NUM_CH): channel selected for the write.
REQ-008 Port Label_adr, input, LABEL_W: table address for the write.
REQ-009 Port Label_en, input, 1: enable bit value to store.
REQ-010 Port Clr, input, 1: pulse that starts the clear-all sweep.
REQ-011 Port Busy, output, 1: high while the clear sweep runs.
REQ-012 Port Wr_err, output, 1: one-cycle pulse when a write is rejected.
REQ-013 Port Chk_vld, input, 1: lookup request.
REQ-014 Port Chk_ch, input, clog2(NUM_CH): channel for the lookup.
REQ-015 Port Label_in, input, LABEL_W: received label to check.
REQ-016 Port Bypass, input, NUM_CH: per-channel accept-all mode.
REQ-017 Port Match_vld, output, 1: lookup result valid.
REQ-018 Port Match_ch, output, clog2(NUM_CH): channel of the result.
REQ-019 Port Label_out, output, 1: 1 = label accepted.
REQ-020 Port Cnt_sel, input, clog2(NUM_CH): counter read select.
REQ-021 Port Cnt_out, output, CNT_W: accepted-word count of the selected channel (combinational mux).

Function
REQ-022 Lookup latency SHALL be one cycle: Chk_vld at edge N gives Match_vld=1 at edge N+1, with Match_ch=Chk_ch and Label_out=Bypass[ch] | table[ch][Label_in].
REQ-023 Match_vld SHALL be 0 in any cycle without a preceding Chk_vld; Label_out SHALL be 0 whenever Match_vld=0.
REQ-024 A write with Wr=1 while Busy=0 SHALL update table[Wr_ch][Label_adr]=Label_en at the clock edge.
REQ-025 When Wr and Chk_vld target the same channel and address in the same cycle, the lookup SHALL return the pre-write value.
REQ-026 The FSM SHALL have two states: IDLE and CLEAR; IDLE->CLEAR on Clr=1; CLEAR->IDLE after address 2**LABEL_W-1 is cleared.
REQ-027 In CLEAR, the sweep address SHALL start at 0, increment by one per cycle, and clear that address in all channels simultaneously; a sweep SHALL last exactly 2**LABEL_W cycles.
REQ-028 Busy SHALL be high from the cycle after Clr through the final sweep cycle.
REQ-029 Clr asserted while in CLEAR SHALL restart the sweep at address 0.
REQ-030 Wr while Busy=1 SHALL be ignored and SHALL produce Wr_err=1 in the following cycle.
REQ-031 A lookup while Busy=1 SHALL return Label_out=Bypass[ch] only, ignoring table contents.
REQ-032 On each result with Label_out=1, counter[Match_ch] SHALL increment by 1 and saturate at 2**CNT_W-1 (no wrap).
REQ-033 A Chk_ch or Wr_ch value >= NUM_CH SHALL be ignored: no write is performed, no Match_vld is raised, and Wr_err pulses for the write.

Reset
REQ-034 Rst_n=0 SHALL asynchronously clear all table bits, all counters, the sweep address, Busy, Wr_err, Match_vld, Match_ch and Label_out, and force the FSM to IDLE.
REQ-035 Reset asserted mid-sweep SHALL abort the sweep; after release the block SHALL be in IDLE with Busy=0.

Structure
REQ-036 Shared package label_pkg SHALL hold the FSM state enum (IDLE, CLEAR) and the default constants for LABEL_W and CNT_W.
REQ-037 Sub-module label_table SHALL implement a single channel's enable bits, write port, clear port and registered read; the top level instantiates NUM_CH copies of it.

Verification
REQ-038 Scenario: Wr ch0 adr 5 en 1, then Chk ch0 label 5 -> Match_vld=1, Label_out=1 one cycle later; Chk ch1 label 5 -> Label_out=0.
REQ-039 Scenario: Wr and Chk in the same cycle on ch0 adr 9 (old value 0, new 1) -> Label_out=0; a repeat Chk -> 1.
REQ-040 Scenario: populate adr 0, 128 and 255 on both channels, then Clr -> Busy high for exactly 256 cycles; a Wr mid-sweep -> Wr_err=1; afterwards all lookups return 0.
REQ-041 Scenario: Bypass=2'b10 with an empty table -> ch1 lookups return 1 and ch0 lookups return 0, including during a sweep.
REQ-042 Scenario: CNT_W=4 with 20 accepted words on ch0 -> Cnt_out (Cnt_sel=0) saturates at 15; ch1 count stays 0.
REQ-043 Scenario: Rst_n low at sweep address 100 -> Busy=0 immediately; table all 0 and counters 0 after release.
